turn_scan_ctrl: RTL and testbench
=================================

# turn_scan_ctrl

Scan controller for the turn-direction path. It polls the four wheel-speed channels in sequence over a shared single-channel sensor interface with a req/ack handshake, and latches a coherent speed set. It then computes the left/right averages and publishes a debounced direction code (00 straight, 01 left, 10 right). It sits between the wheel-speed sensor front end and the ABS/stability logic that consumes `direction`.

## Interface
Parameters:
- `SPEED_W`, 16: wheel-speed width.
- `SCAN_DIV`, 1000: idle cycles between completed scans.
- `PERSIST`, 4: consecutive identical raw results required before `direction` changes (≥1).
- `TIMEOUT`, 64: max cycles waiting for `sens_ack`.
- `HYST`, 8: dead-band in speed units, used only with `TURN_HYST_EN`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `scan_en`, in, 1: enables periodic scanning.
- `sens_req`, out, 1: read request to the sensor interface.
- `sens_sel`, out, 2: channel. 0 = fl, 1 = fr, 2 = rl, 3 = rr.
- `sens_ack`, in, 1: data valid for the current request.
- `sens_data`, in, `SPEED_W`: speed sample, valid when `sens_ack` = 1.
- `speed_fl`, `speed_fr`, `speed_rl`, `speed_rr`, out, `SPEED_W` each: last complete, coherent scan.
- `direction`, out, 2: debounced direction.
- `dir_valid`, out, 1: one-cycle pulse per completed evaluation.
- `sens_fault`, out, 1: sticky ack timeout. Cleared by `rst` or by the next successful scan.

## Operation
- FSM states: `IDLE`, `WAIT`, `REQ`, `GAP`, `EVAL`.
- `IDLE`: go to `REQ` (sel 0) when `scan_en` = 1.
- `WAIT`: count `SCAN_DIV` cycles.
  - At terminal count, go to `REQ` (sel 0) if `scan_en` = 1, else `IDLE`.
  - `scan_en` is only sampled in `IDLE`/`WAIT`; a started scan always completes or times out.
- `REQ`: `sens_req` = 1, `sens_sel` stable. On `sens_ack` = 1:
  - capture `sens_data` into a shadow register;
  - go to `GAP` if sel < 3, else `EVAL`.
- `GAP`: `sens_req` = 0 for exactly one cycle, sel increments, return to `REQ`.
- Timeout in `REQ`: if no ack after `TIMEOUT` cycles, set `sens_fault`, drop `sens_req`, discard the shadow set and go to `WAIT`. `direction`, the speed outputs and the persistence state are unchanged.
- `EVAL` (one cycle):
  - Copy shadow registers to the `speed_*` outputs.
  - `avg_l` = (fl + rl) >> 1, `avg_r` = (fr + rr) >> 1. Sums are computed at `SPEED_W`+1 bits; the shifted result is `SPEED_W` bits with no overflow.
  - `raw` = 10 if `avg_l` > `avg_r`, 01 if `avg_r` > `avg_l`, else 00.
  - Persistence:
    - if `raw` equals the previous `raw`, the counter increments, saturating at `PERSIST`;
    - otherwise the counter resets to 1;
    - when the counter reaches `PERSIST`, `direction` ← `raw`.
  - Clear `sens_fault`, pulse `dir_valid`, go to `WAIT`.
- `sens_ack` outside `REQ` is ignored.
- `sens_ack` in the same cycle as the timeout terminal count counts as an ack; success wins.

## Timing
- Reset values:
  - state `IDLE`, sel 0;
  - `sens_req` 0, `sens_sel` 0;
  - all `speed_*` 0;
  - `direction` 00, `dir_valid` 0, `sens_fault` 0;
  - persistence counter 0, previous `raw` 00.
- `rst` mid-scan: `sens_req` is low the cycle after the reset edge, and the partial scan is discarded.
- `sens_req` rises the cycle after leaving `IDLE`/`WAIT`.
- Data is sampled on the edge where `sens_req` & `sens_ack` = 1. `sens_req` is low the following cycle.
- rr ack sampled at the end of cycle N → `EVAL` in N+1 → `direction`, `speed_*` and `dir_valid` visible in N+2.
- With single-cycle acks, one scan from first `sens_req` to `dir_valid` takes 9 cycles.
- `dir_valid` is never asserted on two consecutive cycles.

## Configuration
- `TURN_HYST_EN` defined: `raw` = 10 only if `avg_l` > `avg_r` + `HYST`, 01 only if `avg_r` > `avg_l` + `HYST`, else 00. The additions are at `SPEED_W`+1 bits, so there is no wrap-around near full scale.
- `TURN_HYST_EN` undefined: strict comparison as described in Operation; `HYST` is unused.

## Structure
- Shared include `turn_defs.vh`:
  - direction codes `DIR_STRAIGHT`/`DIR_LEFT`/`DIR_RIGHT`;
  - channel indices `CH_FL`..`CH_RR`;
  - FSM state encodings.
- Sub-module `turn_eval`: combinational averaging plus compare (with optional hysteresis), producing `raw`.
- FSM, handshake, timeout and persistence stay in `turn_scan_ctrl`.

## Test plan
- Basic scan: `scan_en` = 1, ack one cycle after each req, speeds fl = rl = 100, fr = rr = 80 → `sens_sel` sequence 0,1,2,3 with a one-cycle low gap on `sens_req`; `dir_valid` each scan; `direction` = 10 after the 4th scan, 00 before.
- Left/reversal: fl = rl = 50, fr = rr = 70 for 3 scans, then left = 90 / right = 70 → `direction` stays 00. The persistence counter restarts, so 10 appears only after 4 further scans.
- Averaging width: all speeds = 16'hFFFF, then fl = 16'hFFFF, rl = 16'hFFFE, fr = rr = 16'hFFFF → `avg_l` = 16'hFFFE, `avg_r` = 16'hFFFF, `raw` = 01, no overflow.
- Timeout: withhold ack on channel 2 for 64 cycles → `sens_fault` = 1, `sens_req` drops, `direction`/`speed_*` unchanged, no `dir_valid`. The next good scan clears `sens_fault`.
- Reset mid-scan: assert `rst` while `sens_req` = 1 on channel 1 → the next cycle has `sens_req` = 0 and all outputs at reset values. The next scan restarts at sel 0.
- `TURN_HYST_EN`, `HYST` = 8: left = 100 / right = 95 for 4 scans → 00; left = 100 / right = 91 → 10 after 4 scans.

Source files
------------

// File: rtl/turn_scan_ctrl_pkg.sv
// Shared constants and FSM state type for the turn-direction scan controller.
package turn_scan_ctrl_pkg;

  localparam logic [1:0] DIR_STRAIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT     = 2'b01;
  localparam logic [1:0] DIR_RIGHT    = 2'b10;

  localparam logic [1:0] CH_FL = 2'd0;
  localparam logic [1:0] CH_FR = 2'd1;
  localparam logic [1:0] CH_RL = 2'd2;
  localparam logic [1:0] CH_RR = 2'd3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StReq  = 3'd2,
    StGap  = 3'd3,
    StEval = 3'd4
  } state_e;

endpackage

// File: rtl/turn_eval.sv
// Combinational left/right wheel-speed averaging and compare, producing the raw direction code.
// Define TURN_HYST_EN to require the averages to differ by more than HYST.
module turn_eval
  import turn_scan_ctrl_pkg::*;
#(
  parameter int unsigned SPEED_W = 16,
  parameter int unsigned HYST    = 8
) (
  input  logic [SPEED_W-1:0] speed_fl,
  input  logic [SPEED_W-1:0] speed_fr,
  input  logic [SPEED_W-1:0] speed_rl,
  input  logic [SPEED_W-1:0] speed_rr,
  output logic [1:0]         raw
);

`ifdef TURN_HYST_EN
  localparam bit HystOn = 1'b1;
`else
  localparam bit HystOn = 1'b0;
`endif
  localparam logic [SPEED_W:0] Band = HystOn ? (SPEED_W + 1)'(HYST) : '0;

  logic [SPEED_W:0]   sum_l, sum_r;
  logic [SPEED_W-1:0] avg_l, avg_r;
  logic [SPEED_W:0]   ext_l, ext_r;

  assign sum_l = {1'b0, speed_fl} + {1'b0, speed_rl};
  assign sum_r = {1'b0, speed_fr} + {1'b0, speed_rr};
  assign avg_l = SPEED_W'(sum_l >> 1);
  assign avg_r = SPEED_W'(sum_r >> 1);

  // One spare bit so adding the dead-band cannot wrap near full scale.
  assign ext_l = {1'b0, avg_l};
  assign ext_r = {1'b0, avg_r};

  // Faster left wheels mean the vehicle is turning right.
  always_comb begin
    raw = DIR_STRAIGHT;
    if (ext_l > ext_r + Band) begin
      raw = DIR_RIGHT;
    end else if (ext_r > ext_l + Band) begin
      raw = DIR_LEFT;
    end
  end

endmodule

// File: rtl/turn_scan_ctrl.sv
// Polls four wheel-speed channels over a req/ack sensor port, latches a coherent set and
// publishes a debounced turn direction. Define TURN_HYST_EN to enable the compare dead-band.
module turn_scan_ctrl
  import turn_scan_ctrl_pkg::*;
#(
  parameter int unsigned SPEED_W  = 16,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned PERSIST  = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned HYST     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_en,
  output logic               sens_req,
  output logic [1:0]         sens_sel,
  input  logic               sens_ack,
  input  logic [SPEED_W-1:0] sens_data,
  output logic [SPEED_W-1:0] speed_fl,
  output logic [SPEED_W-1:0] speed_fr,
  output logic [SPEED_W-1:0] speed_rl,
  output logic [SPEED_W-1:0] speed_rr,
  output logic [1:0]         direction,
  output logic               dir_valid,
  output logic               sens_fault
);

  localparam int unsigned DivW  = $clog2(SCAN_DIV + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam int unsigned PcntW = $clog2(PERSIST + 1);

  localparam logic [DivW-1:0]  DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT - 1);
  localparam logic [PcntW-1:0] PcntMax = PcntW'(PERSIST);

  state_e             state_q, state_d;
  logic [1:0]         sel_q;
  logic [DivW-1:0]    div_q;
  logic [TmoW-1:0]    tmo_q;
  logic [SPEED_W-1:0] sh_fl_q, sh_fr_q, sh_rl_q, sh_rr_q;
  logic [SPEED_W-1:0] spd_fl_q, spd_fr_q, spd_rl_q, spd_rr_q;
  logic [1:0]         raw, prev_raw_q, dir_q;
  logic [PcntW-1:0]   pcnt_q, pcnt_d;
  logic               valid_q, fault_q;
  logic               got_ack, tmo_hit;

  // Success wins over a timeout landing on the same cycle.
  assign got_ack = (state_q == StReq) && sens_ack;
  assign tmo_hit = (state_q == StReq) && !sens_ack && (tmo_q == TmoLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (scan_en) state_d = StReq;
      StWait: if (div_q == DivLast) state_d = scan_en ? StReq : StIdle;
      StReq: begin
        if (got_ack) begin
          state_d = (sel_q == CH_RR) ? StEval : StGap;
        end else if (tmo_hit) begin
          state_d = StWait;
        end
      end
      StGap:   state_d = StReq;
      StEval:  state_d = StWait;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pcnt_d = PcntW'(1);
    if (raw == prev_raw_q) begin
      pcnt_d = (pcnt_q >= PcntMax) ? PcntMax : pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= CH_FL;
      div_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= (state_q == StWait) ? div_q + 1'b1 : '0;
      tmo_q   <= (state_q == StReq) ? tmo_q + 1'b1 : '0;
      if (state_q == StGap) begin
        sel_q <= sel_q + 2'd1;
      end else if (state_q != StReq) begin
        sel_q <= CH_FL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_fl_q    <= '0;
      sh_fr_q    <= '0;
      sh_rl_q    <= '0;
      sh_rr_q    <= '0;
      spd_fl_q   <= '0;
      spd_fr_q   <= '0;
      spd_rl_q   <= '0;
      spd_rr_q   <= '0;
      dir_q      <= DIR_STRAIGHT;
      prev_raw_q <= DIR_STRAIGHT;
      pcnt_q     <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      valid_q <= (state_q == StEval);
      if (got_ack) begin
        unique case (sel_q)
          CH_FL: sh_fl_q <= sens_data;
          CH_FR: sh_fr_q <= sens_data;
          CH_RL: sh_rl_q <= sens_data;
          CH_RR: sh_rr_q <= sens_data;
          default: ;
        endcase
      end
      // A timed-out scan leaves outputs and persistence untouched; the shadow set is
      // fully overwritten by the next scan before it is ever used.
      if (tmo_hit) begin
        fault_q <= 1'b1;
      end
      if (state_q == StEval) begin
        spd_fl_q   <= sh_fl_q;
        spd_fr_q   <= sh_fr_q;
        spd_rl_q   <= sh_rl_q;
        spd_rr_q   <= sh_rr_q;
        pcnt_q     <= pcnt_d;
        prev_raw_q <= raw;
        fault_q    <= 1'b0;
        if (pcnt_d == PcntMax) begin
          dir_q <= raw;
        end
      end
    end
  end

  turn_eval #(
    .SPEED_W (SPEED_W),
    .HYST    (HYST)
  ) u_eval (
    .speed_fl (sh_fl_q),
    .speed_fr (sh_fr_q),
    .speed_rl (sh_rl_q),
    .speed_rr (sh_rr_q),
    .raw      (raw)
  );

  assign sens_req   = (state_q == StReq);
  assign sens_sel   = sel_q;
  assign speed_fl   = spd_fl_q;
  assign speed_fr   = spd_fr_q;
  assign speed_rl   = spd_rl_q;
  assign speed_rr   = spd_rr_q;
  assign direction  = dir_q;
  assign dir_valid  = valid_q;
  assign sens_fault = fault_q;

endmodule

// File: tb/tb_turn_scan_ctrl.sv
// Self-checking bench for turn_scan_ctrl: drives the sensor handshake and compares every
// evaluation against a behavioural model of averaging, compare and persistence.
module tb_turn_scan_ctrl;

  localparam int unsigned SPEED_W  = 16;
  localparam int unsigned SCAN_DIV = 12;
  localparam int unsigned PERSIST  = 4;
  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned HYST     = 8;

`ifdef TURN_HYST_EN
  localparam bit HystOn = 1'b1;
`else
  localparam bit HystOn = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               scan_en;
  logic               sens_req;
  logic [1:0]         sens_sel;
  logic               sens_ack;
  logic [SPEED_W-1:0] sens_data;
  logic [SPEED_W-1:0] speed_fl, speed_fr, speed_rl, speed_rr;
  logic [1:0]         direction;
  logic               dir_valid;
  logic               sens_fault;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [1:0]  hist [$];
  logic [1:0]  exp_dir;
  logic [15:0] exp_spd [4];
  bit          exp_fault;
  bit          noise;

  always #5 clk = ~clk;

  turn_scan_ctrl #(
    .SPEED_W  (SPEED_W),
    .SCAN_DIV (SCAN_DIV),
    .PERSIST  (PERSIST),
    .TIMEOUT  (TIMEOUT),
    .HYST     (HYST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .sens_req   (sens_req),
    .sens_sel   (sens_sel),
    .sens_ack   (sens_ack),
    .sens_data  (sens_data),
    .speed_fl   (speed_fl),
    .speed_fr   (speed_fr),
    .speed_rl   (speed_rl),
    .speed_rr   (speed_rr),
    .direction  (direction),
    .dir_valid  (dir_valid),
    .sens_fault (sens_fault)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] ref_raw(input int fl, input int fr, input int rl, input int rr);
    int al, ar, h;
    al = (fl + rl) / 2;
    ar = (fr + rr) / 2;
    h  = HystOn ? int'(HYST) : 0;
    if (al > ar + h) return 2'b10;
    if (ar > al + h) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_dir   = 2'b00;
    exp_fault = 1'b0;
    for (int i = 0; i < 4; i++) exp_spd[i] = 16'h0;
  endtask

  // Direction follows raw once the last PERSIST evaluations since reset all agree.
  task automatic model_eval(input logic [15:0] fl, input logic [15:0] fr,
                            input logic [15:0] rl, input logic [15:0] rr);
    logic [1:0] r;
    bit same;
    r = ref_raw(int'(fl), int'(fr), int'(rl), int'(rr));
    hist.push_back(r);
    if (hist.size() >= int'(PERSIST)) begin
      same = 1'b1;
      for (int i = 0; i < int'(PERSIST); i++) begin
        if (hist[hist.size() - 1 - i] != r) same = 1'b0;
      end
      if (same) exp_dir = r;
    end
    exp_spd[0] = fl;
    exp_spd[1] = fr;
    exp_spd[2] = rl;
    exp_spd[3] = rr;
    exp_fault  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One scan; a per-channel delay >= TIMEOUT withholds that ack entirely.
  task automatic scan(input logic [15:0] fl, input logic [15:0] fr, input logic [15:0] rl,
                      input logic [15:0] rr, input int d0, input int d1, input int d2,
                      input int d3, input bit en_after);
    logic [15:0] v [4];
    int d [4];
    int waited, lat, dsum;
    bit stray, stable;
    v[0] = fl; v[1] = fr; v[2] = rl; v[3] = rr;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    waited = 0;
    stray  = 1'b0;
    while (sens_req !== 1'b1 && waited < 4 * int'(SCAN_DIV)) begin
      if (dir_valid === 1'b1) stray = 1'b1;
      if (noise) begin
        sens_ack  = 1'($urandom_range(0, 1));
        sens_data = 16'($urandom);
      end
      @(negedge clk);
      waited++;
    end
    sens_ack = 1'b0;
    checks++;
    if (sens_req !== 1'b1 || stray) begin
      errors++;
      $display("FAIL scan_start: req=%b stray_valid=%b after %0d cycles, required req=1 no valid",
               sens_req, stray, waited);
      return;
    end
    checks++;
    if (sens_fault !== exp_fault) begin
      errors++;
      $display("FAIL fault_hold: sens_fault=%b required %b", sens_fault, exp_fault);
    end
    lat  = 0;
    dsum = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (ch > 0) begin
        checks++;
        if (sens_req !== 1'b0) begin
          errors++;
          $display("FAIL gap_low: ch=%0d sens_req=%b required 0", ch, sens_req);
        end
        if (noise) begin
          sens_ack  = 1'b1;
          sens_data = 16'($urandom);
        end
        @(negedge clk);
        lat++;
        sens_ack = 1'b0;
      end
      checks++;
      if (sens_req !== 1'b1 || sens_sel !== 2'(ch)) begin
        errors++;
        $display("FAIL sel: req=%b sel=%0d required req=1 sel=%0d", sens_req, sens_sel, ch);
      end
      if (ch == 0) scan_en = en_after;
      if (d[ch] >= int'(TIMEOUT)) begin
        stable = 1'b1;
        for (int k = 1; k < int'(TIMEOUT); k++) begin
          @(negedge clk);
          if (sens_req !== 1'b1 || sens_sel !== 2'(ch)) stable = 1'b0;
        end
        @(negedge clk);
        exp_fault = 1'b1;
        checks++;
        if (!stable || sens_req !== 1'b0) begin
          errors++;
          $display("FAIL tmo_req: held=%b req_after=%b required held=1 req_after=0",
                   stable, sens_req);
        end
        checks++;
        if (sens_fault !== 1'b1 || dir_valid !== 1'b0 || direction !== exp_dir ||
            {speed_fl, speed_fr, speed_rl, speed_rr} !==
            {exp_spd[0], exp_spd[1], exp_spd[2], exp_spd[3]}) begin
          errors++;
          $display("FAIL tmo_state: fault=%b valid=%b dir=%b spd=%h %h %h %h required 1 0 %b %h %h %h %h",
                   sens_fault, dir_valid, direction, speed_fl, speed_fr, speed_rl, speed_rr,
                   exp_dir, exp_spd[0], exp_spd[1], exp_spd[2], exp_spd[3]);
        end
        return;
      end
      stable = 1'b1;
      for (int k = 0; k < d[ch]; k++) begin
        @(negedge clk);
        lat++;
        if (sens_req !== 1'b1 || sens_sel !== 2'(ch)) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
        errors++;
        $display("FAIL req_stable: ch=%0d req/sel changed while waiting for ack", ch);
      end
      dsum += d[ch];
      sens_ack  = 1'b1;
      sens_data = v[ch];
      @(negedge clk);
      lat++;
      sens_ack = 1'b0;
    end
    checks++;
    if (sens_req !== 1'b0 || dir_valid !== 1'b0) begin
      errors++;
      $display("FAIL eval_cycle: req=%b valid=%b required 0 0", sens_req, dir_valid);
    end
    if (noise) begin
      sens_ack  = 1'b1;
      sens_data = 16'($urandom);
    end
    @(negedge clk);
    lat++;
    sens_ack = 1'b0;
    model_eval(fl, fr, rl, rr);
    checks++;
    if (dir_valid !== 1'b1) begin
      errors++;
      $display("FAIL dir_valid: got %b required 1", dir_valid);
    end
    checks++;
    if (direction !== exp_dir) begin
      errors++;
      $display("FAIL direction: got %b required %b (fl=%0d fr=%0d rl=%0d rr=%0d)",
               direction, exp_dir, fl, fr, rl, rr);
    end
    checks++;
    if ({speed_fl, speed_fr, speed_rl, speed_rr} !==
        {exp_spd[0], exp_spd[1], exp_spd[2], exp_spd[3]}) begin
      errors++;
      $display("FAIL speeds: got %h %h %h %h required %h %h %h %h", speed_fl, speed_fr,
               speed_rl, speed_rr, exp_spd[0], exp_spd[1], exp_spd[2], exp_spd[3]);
    end
    checks++;
    if (sens_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: sens_fault=%b required 0", sens_fault);
    end
    // First req cycle to dir_valid cycle inclusive is 9 cycles plus any ack delay.
    checks++;
    if (lat != 8 + dsum) begin
      errors++;
      $display("FAIL latency: got %0d cycles required %0d", lat + 1, 9 + dsum);
    end
    @(negedge clk);
    checks++;
    if (dir_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: dir_valid=%b on second cycle required 0", dir_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    scan_en   = 1'b0;
    sens_ack  = 1'b0;
    sens_data = '0;
    noise     = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    checks++;
    if (sens_req !== 1'b0) begin
      errors++; $display("FAIL rst_req: got %b required 0", sens_req);
    end
    checks++;
    if (sens_sel !== 2'd0) begin
      errors++; $display("FAIL rst_sel: got %0d required 0", sens_sel);
    end
    checks++;
    if ({speed_fl, speed_fr, speed_rl, speed_rr} !== 64'h0) begin
      errors++; $display("FAIL rst_speeds: got %h %h %h %h required 0", speed_fl, speed_fr,
                         speed_rl, speed_rr);
    end
    checks++;
    if (direction !== 2'b00) begin
      errors++; $display("FAIL rst_dir: got %b required 00", direction);
    end
    checks++;
    if (dir_valid !== 1'b0 || sens_fault !== 1'b0) begin
      errors++; $display("FAIL rst_flags: valid=%b fault=%b required 0 0", dir_valid, sens_fault);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sens_req !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got %b required 0 with scan_en=0", sens_req);
    end
  endtask

  task automatic test_basic();
    scan_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      scan(16'd100, 16'd80, 16'd100, 16'd80, 0, 0, 0, 0, 1'b1);
      checks++;
      if (direction !== ((i == 3) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL basic_dir: scan %0d got %b required %b", i, direction,
                 (i == 3) ? 2'b10 : 2'b00);
      end
    end
  endtask

  task automatic test_reversal();
    do_reset();
    for (int i = 0; i < 3; i++) scan(16'd50, 16'd70, 16'd50, 16'd70, 1, 0, 2, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      scan(16'd90, 16'd70, 16'd90, 16'd70, 0, 1, 0, 1, 1'b1);
      checks++;
      if (direction !== ((i == 3) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL reversal_dir: scan %0d got %b required %b", i, direction,
                 (i == 3) ? 2'b10 : 2'b00);
      end
    end
  endtask

  task automatic test_width();
    for (int i = 0; i < 4; i++) scan(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) scan(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 0, 0, 0, 0, 1'b1);
    checks++;
    if (direction !== (HystOn ? 2'b00 : 2'b01)) begin
      errors++;
      $display("FAIL width_dir: got %b required %b", direction, HystOn ? 2'b00 : 2'b01);
    end
  endtask

  task automatic test_timeout();
    // Three right-turn evaluations, a lost scan, then one more: the run must survive.
    for (int i = 0; i < 3; i++) scan(16'd300, 16'd100, 16'd300, 16'd100, 0, 0, 0, 0, 1'b1);
    scan(16'd1, 16'd2, 16'd3, 16'd4, 0, 0, TIMEOUT, 0, 1'b1);
    scan(16'd300, 16'd100, 16'd300, 16'd100, 0, 0, 0, 0, 1'b1);
    checks++;
    if (direction !== 2'b10) begin
      errors++; $display("FAIL tmo_persist: got %b required 10", direction);
    end
    // Ack on the last allowed cycle is a success.
    scan(16'd10, 16'd20, 16'd30, 16'd40, 0, TIMEOUT - 1, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    int waited;
    waited = 0;
    while (!(sens_req === 1'b1 && sens_sel === 2'd0) && waited < 4 * int'(SCAN_DIV)) begin
      @(negedge clk);
      waited++;
    end
    sens_ack  = 1'b1;
    sens_data = 16'h1234;
    @(negedge clk);
    sens_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (sens_req !== 1'b1 || sens_sel !== 2'd1) begin
      errors++; $display("FAIL mid_setup: req=%b sel=%0d required 1 1", sens_req, sens_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    checks++;
    if (sens_req !== 1'b0 || sens_sel !== 2'd0 || direction !== 2'b00 || dir_valid !== 1'b0 ||
        sens_fault !== 1'b0 || {speed_fl, speed_fr, speed_rl, speed_rr} !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset: req=%b sel=%0d dir=%b valid=%b fault=%b spd=%h%h%h%h required all 0",
               sens_req, sens_sel, direction, dir_valid, sens_fault, speed_fl, speed_fr,
               speed_rl, speed_rr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sens_req !== 1'b1 || sens_sel !== 2'd0) begin
      errors++; $display("FAIL restart: req=%b sel=%0d required 1 0", sens_req, sens_sel);
    end
    scan(16'd500, 16'd400, 16'd500, 16'd400, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_idle();
    bit quiet;
    scan(16'd60, 16'd60, 16'd60, 16'd60, 0, 0, 0, 0, 1'b0);
    quiet = 1'b1;
    repeat (3 * SCAN_DIV) begin
      @(negedge clk);
      if (sens_req !== 1'b0 || dir_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL idle_quiet: activity seen with scan_en=0, required none");
    end
    scan_en = 1'b1;
    @(negedge clk);
    checks++;
    if (sens_req !== 1'b1) begin
      errors++; $display("FAIL idle_start: sens_req=%b one cycle after scan_en, required 1",
                         sens_req);
    end
    scan(16'd60, 16'd61, 16'd60, 16'd61, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_hyst();
    do_reset();
    for (int i = 0; i < 4; i++) scan(16'd100, 16'd95, 16'd100, 16'd95, 0, 0, 0, 0, 1'b1);
    checks++;
    if (direction !== (HystOn ? 2'b00 : 2'b10)) begin
      errors++; $display("FAIL hyst_inside: got %b required %b", direction,
                         HystOn ? 2'b00 : 2'b10);
    end
    for (int i = 0; i < 4; i++) scan(16'd100, 16'd91, 16'd100, 16'd91, 0, 0, 0, 0, 1'b1);
    checks++;
    if (direction !== 2'b10) begin
      errors++; $display("FAIL hyst_outside: got %b required 10", direction);
    end
  endtask

  task automatic test_random();
    logic [15:0] p [4];
    int dd [4];
    int base;
    noise = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if (it == 0 || $urandom_range(0, 9) < 3) begin
        base = (($urandom_range(0, 7) == 0) ? 65535 - 40 : int'($urandom_range(0, 65000)));
        for (int i = 0; i < 4; i++) p[i] = 16'(base + int'($urandom_range(0, 40)));
      end
      for (int i = 0; i < 4; i++) dd[i] = int'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0: dd[$urandom_range(0, 3)] = int'(TIMEOUT);
        1: dd[$urandom_range(0, 3)] = int'(TIMEOUT) - 1;
        default: ;
      endcase
      scan(p[0], p[1], p[2], p[3], dd[0], dd[1], dd[2], dd[3], 1'b1);
    end
    noise    = 1'b0;
    sens_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reversal();
    test_width();
    test_timeout();
    test_reset_mid_scan();
    test_idle();
    test_hyst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
